// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: requester and timer signals shared by the arbiter and its environment
interface timer_arbiter_if #(
  parameter int NREQ = 4,
  parameter int SIZE = 5
);
  logic                 clk_en;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] dly_bus;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic                 timer_en;
  logic [SIZE-1:0]      time_dly;
  logic                 timeout;
  modport slave (
    input  clk_en, req, dly_bus, timeout,
    output grant, done, busy, timer_en, time_dly
  );
  modport master (
    output clk_en, req, dly_bus, timeout,
    input  grant, done, busy, timer_en, time_dly
  );
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin owner of one shared timer; define TIMER_ARB_ABORT_EN to let a requester abort its grant by dropping req
module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int SIZE = 5
) (
  input logic cpld_50m_clk,
  input logic cpld_rst_n_50m,
  timer_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, last, last_n, pick, j;
  logic [SIZE-1:0] dly, dly_n, pick_dly, time_dly_n;
  logic [NREQ-1:0] grant_n, done_n;
  logic pick_ok, abort, owns, busy_n, timer_en_n;
`ifdef TIMER_ARB_ABORT_EN
  assign abort = !bus.req[idx];
`else
  assign abort = 1'b0;
`endif
  // first set request strictly after last, wrapping; lowest offset wins
  always_comb begin
    pick_ok = 1'b0;
    pick = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(last) + k) % NREQ);
      if (bus.req[j]) begin
        pick_ok = 1'b1;
        pick = j;
      end
    end
  end
  // delay slice of the picked requester
  always_comb begin
    pick_dly = '0;
    for (int i = 0; i < NREQ; i++) pick_dly = (pick == IW'(i)) ? bus.dly_bus[i*SIZE +: SIZE] : pick_dly;
  end
  // next state plus the registered output values that state implies
  always_comb begin
    state_n = state;
    idx_n = idx;
    dly_n = dly;
    last_n = last;
    case (state)
      IDLE: if (pick_ok) begin
        state_n = LOAD;
        idx_n = pick;
        dly_n = pick_dly;
      end
      LOAD: state_n = abort ? IDLE : RUN;
      RUN: state_n = abort ? IDLE : bus.timeout ? DONE : RUN;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    last_n = (state == DONE || ((state == LOAD || state == RUN) && abort)) ? idx : last;
    owns = state_n == LOAD || state_n == RUN;
    grant_n = owns ? ONE << idx_n : '0;
    timer_en_n = owns;
    time_dly_n = owns ? dly_n : '0;
    busy_n = state_n != IDLE;
    done_n = state_n == DONE ? ONE << idx : '0;
  end
  // state and every output are registered
  always_ff @(posedge cpld_50m_clk) begin
    if (!cpld_rst_n_50m) begin
      state <= IDLE;
      idx <= '0;
      dly <= '0;
      last <= IW'(NREQ - 1);
      bus.grant <= '0;
      bus.done <= '0;
      bus.busy <= 1'b0;
      bus.timer_en <= 1'b0;
      bus.time_dly <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      dly <= dly_n;
      last <= last_n;
      bus.grant <= grant_n;
      bus.done <= done_n;
      bus.busy <= busy_n;
      bus.timer_en <= timer_en_n;
      bus.time_dly <= time_dly_n;
    end
  end
endmodule
